reservation_station: RTL and testbench
======================================

# reservation_station

Single-entry Tomasulo reservation station. Sits between dispatch and one functional unit (FU). Holds one pending operation and its two operands, snoops the common data bus (CDB) through two operand listeners until both operands are valid, and issues to the FU with a valid/ready handshake. The entry's own tag stays reserved until the FU result appears on the CDB under that tag.

## Interface
- DATA_WIDTH, 4, operand/data word width
- CDB_TAG_WIDTH, 4, CDB tag width; must be ≤ DATA_WIDTH
- OP_WIDTH, 2, opcode width
- RS_ID, 1, this entry's CDB tag (CDB_TAG_WIDTH bits); the FU broadcasts the result under it
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous squash of the entry
- dispatch_valid  in  1  dispatch offers an operation
- dispatch_ready  out  1  entry can accept
- dispatch_op  in  OP_WIDTH  opcode
- dispatch_a / dispatch_b  in  DATA_WIDTH  operand value, or producer tag in low CDB_TAG_WIDTH bits
- dispatch_a_is_valid / dispatch_b_is_valid  in  1  1 = value, 0 = tag
- cdb_in_valid  in  1; cdb_in_tag  in  CDB_TAG_WIDTH; cdb_in_data  in  DATA_WIDTH  CDB broadcast
- issue_valid  out  1  operation ready for FU
- issue_ready  in  1  FU accepts
- issue_op  out  OP_WIDTH; issue_a / issue_b  out  DATA_WIDTH; issue_tag  out  CDB_TAG_WIDTH (= RS_ID)

## Operation
- States: FREE, WAITING, ISSUED. Registered; reset → FREE.
- dispatch_ready = (state==FREE) && !flush. Accept = dispatch_valid && dispatch_ready.
- FREE, accept → WAITING. Latch dispatch_op. Pulse command_update_en to both listeners with the dispatch operand and is_valid bits.
- WAITING: listeners snoop the CDB. issue_valid = (state==WAITING) && a_valid && b_valid && !flush.
- WAITING, issue_valid && issue_ready → ISSUED.
- ISSUED, cdb_in_valid && cdb_in_tag==RS_ID → FREE.
- flush (any state) → FREE next cycle. Overrides accept, issue and CDB release. rst has priority over flush.
- Same-cycle forwarding: if the dispatched operand tag matches the CDB broadcast in the accept cycle, the operand is captured as valid. The listener performs this.
- A CDB broadcast of RS_ID while in FREE or WAITING is ignored by the state machine.
- issue_a/issue_b/issue_op are don't-care while issue_valid=0.
- Listener contents are not reset. The state gates every use of them.

## Timing
- After rst: state FREE, dispatch_ready=1 (if flush=0), issue_valid=0.
- Dispatch to issue_valid, both operands valid at dispatch: 1 cycle (issue_valid high in cycle after accept).
- Operand arriving on CDB in cycle t while WAITING: issue_valid high from t+1 if the other operand is valid.
- issue_valid holds, with stable issue_* values, until issue_ready. No retraction except flush/rst.
- Release: CDB hit on RS_ID in ISSUED at cycle t → dispatch_ready=1 at t+1, never at t.
- Back-to-back throughput: one operation per FREE→WAITING→ISSUED→FREE loop, minimum 3 cycles.

## Structure
- Shared package rs_pkg: state encoding constants (RS_FREE=2'd0, RS_WAITING=2'd1, RS_ISSUED=2'd2) and the default OP_WIDTH.
- Two instances of cdb_result_listener (operand A, operand B), same DATA_WIDTH/CDB_TAG_WIDTH. No other sub-modules.
- Top level holds the state register, opcode register and handshake logic.

## Test plan
- Reset, then dispatch op=2, a=5 valid, b=3 valid → issue_valid=1 next cycle with a=5, b=3, op=2, issue_tag=RS_ID. issue_ready=1 → ISSUED, dispatch_ready=0.
- Dispatch a=tag 3 (invalid), b=7 valid; 2 cycles later CDB {tag 3, data 9} → issue_valid=1 the following cycle with a=9, b=7.
- Dispatch a=tag 4 while CDB {tag 4, data 0xA} in the same cycle, b valid → forwarded, issue_valid=1 next cycle with a=0xA.
- In ISSUED, CDB {tag 2 (≠RS_ID)} → stays ISSUED. CDB {tag RS_ID} → dispatch_ready=1 the next cycle, not the same cycle.
- issue_valid=1 with issue_ready=0 for 3 cycles → issue_* stable, then issue_ready=1 → single issue, ISSUED.
- Flush in WAITING with a CDB hit the same cycle → FREE next cycle, issue_valid=0. rst asserted in ISSUED → FREE, dispatch_ready=1 next cycle.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared definitions for the single-entry reservation station:
// the state encoding and the default opcode width.
package rs_pkg;

  localparam int unsigned DEFAULT_OP_WIDTH = 2;

  typedef enum logic [1:0] {
    RS_FREE    = 2'd0,
    RS_WAITING = 2'd1,
    RS_ISSUED  = 2'd2
  } rs_state_e;

endpackage

// File: rtl/cdb_result_listener.sv
// Holds one operand. The operand is either a value or a producer tag; while it
// is a tag, the listener watches the CDB for that tag and captures the result.
module cdb_result_listener #(
  parameter int unsigned DATA_WIDTH    = 4,
  parameter int unsigned CDB_TAG_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     command_update_en,
  input  logic [DATA_WIDTH-1:0]    command_data,
  input  logic                     command_is_valid,
  input  logic                     cdb_valid,
  input  logic [CDB_TAG_WIDTH-1:0] cdb_tag,
  input  logic [DATA_WIDTH-1:0]    cdb_data,
  output logic [DATA_WIDTH-1:0]    data,
  output logic                     data_valid
);

  logic cmd_hit_c;
  logic snoop_hit_c;

  // A new tag can be satisfied by the broadcast in the very cycle it is loaded.
  assign cmd_hit_c   = cdb_valid && (cdb_tag == command_data[CDB_TAG_WIDTH-1:0]);
  assign snoop_hit_c = cdb_valid && !data_valid && (cdb_tag == data[CDB_TAG_WIDTH-1:0]);

  // Contents are deliberately unreset; the owner's state gates their use.
  always_ff @(posedge clk) begin
    if (command_update_en) begin
      if (command_is_valid) begin
        data       <= command_data;
        data_valid <= 1'b1;
      end else if (cmd_hit_c) begin
        data       <= cdb_data;
        data_valid <= 1'b1;
      end else begin
        data       <= command_data;
        data_valid <= 1'b0;
      end
    end else if (snoop_hit_c) begin
      data       <= cdb_data;
      data_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Single-entry Tomasulo reservation station: accepts one operation from
// dispatch, waits for both operands via the CDB, issues it, and holds its tag
// until the FU result is broadcast.
module reservation_station
  import rs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 4,
  parameter int unsigned CDB_TAG_WIDTH = 4,
  parameter int unsigned OP_WIDTH      = DEFAULT_OP_WIDTH,
  parameter int unsigned RS_ID         = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     dispatch_valid,
  output logic                     dispatch_ready,
  input  logic [OP_WIDTH-1:0]      dispatch_op,
  input  logic [DATA_WIDTH-1:0]    dispatch_a,
  input  logic [DATA_WIDTH-1:0]    dispatch_b,
  input  logic                     dispatch_a_is_valid,
  input  logic                     dispatch_b_is_valid,
  input  logic                     cdb_in_valid,
  input  logic [CDB_TAG_WIDTH-1:0] cdb_in_tag,
  input  logic [DATA_WIDTH-1:0]    cdb_in_data,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [OP_WIDTH-1:0]      issue_op,
  output logic [DATA_WIDTH-1:0]    issue_a,
  output logic [DATA_WIDTH-1:0]    issue_b,
  output logic [CDB_TAG_WIDTH-1:0] issue_tag
);

  localparam logic [CDB_TAG_WIDTH-1:0] OWN_TAG = CDB_TAG_WIDTH'(RS_ID);

  rs_state_e           state_q;
  rs_state_e           state_d;
  logic [OP_WIDTH-1:0] op_q;
  logic                accept_c;
  logic                release_c;
  logic                a_valid;
  logic                b_valid;

  assign dispatch_ready = (state_q == RS_FREE) && !flush;
  assign accept_c       = dispatch_valid && dispatch_ready;
  assign issue_valid    = (state_q == RS_WAITING) && a_valid && b_valid && !flush;
  assign release_c      = cdb_in_valid && (cdb_in_tag == OWN_TAG);
  assign issue_op       = op_q;
  assign issue_tag      = OWN_TAG;

  cdb_result_listener #(
    .DATA_WIDTH    (DATA_WIDTH),
    .CDB_TAG_WIDTH (CDB_TAG_WIDTH)
  ) u_listener_a (
    .clk               (clk),
    .command_update_en (accept_c),
    .command_data      (dispatch_a),
    .command_is_valid  (dispatch_a_is_valid),
    .cdb_valid         (cdb_in_valid),
    .cdb_tag           (cdb_in_tag),
    .cdb_data          (cdb_in_data),
    .data              (issue_a),
    .data_valid        (a_valid)
  );

  cdb_result_listener #(
    .DATA_WIDTH    (DATA_WIDTH),
    .CDB_TAG_WIDTH (CDB_TAG_WIDTH)
  ) u_listener_b (
    .clk               (clk),
    .command_update_en (accept_c),
    .command_data      (dispatch_b),
    .command_is_valid  (dispatch_b_is_valid),
    .cdb_valid         (cdb_in_valid),
    .cdb_tag           (cdb_in_tag),
    .cdb_data          (cdb_in_data),
    .data              (issue_b),
    .data_valid        (b_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RS_FREE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_c) begin
      op_q <= dispatch_op;
    end
  end

  // Flush squashes from any state; own-tag broadcasts only matter once issued.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = RS_FREE;
    end else begin
      unique case (state_q)
        RS_FREE:    if (accept_c) state_d = RS_WAITING;
        RS_WAITING: if (issue_valid && issue_ready) state_d = RS_ISSUED;
        RS_ISSUED:  if (release_c) state_d = RS_FREE;
        default:    state_d = RS_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: dispatch, CDB wakeup, forwarding,
// issue backpressure, release timing, flush and reset.
module tb_reservation_station;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       dispatch_valid;
  logic       dispatch_ready;
  logic [1:0] dispatch_op;
  logic [3:0] dispatch_a;
  logic [3:0] dispatch_b;
  logic       dispatch_a_is_valid;
  logic       dispatch_b_is_valid;
  logic       cdb_in_valid;
  logic [3:0] cdb_in_tag;
  logic [3:0] cdb_in_data;
  logic       issue_valid;
  logic       issue_ready;
  logic [1:0] issue_op;
  logic [3:0] issue_a;
  logic [3:0] issue_b;
  logic [3:0] issue_tag;

  int checks = 0;
  int errors = 0;

  reservation_station #(
    .DATA_WIDTH    (4),
    .CDB_TAG_WIDTH (4),
    .OP_WIDTH      (2),
    .RS_ID         (1)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .dispatch_valid      (dispatch_valid),
    .dispatch_ready      (dispatch_ready),
    .dispatch_op         (dispatch_op),
    .dispatch_a          (dispatch_a),
    .dispatch_b          (dispatch_b),
    .dispatch_a_is_valid (dispatch_a_is_valid),
    .dispatch_b_is_valid (dispatch_b_is_valid),
    .cdb_in_valid        (cdb_in_valid),
    .cdb_in_tag          (cdb_in_tag),
    .cdb_in_data         (cdb_in_data),
    .issue_valid         (issue_valid),
    .issue_ready         (issue_ready),
    .issue_op            (issue_op),
    .issue_a             (issue_a),
    .issue_b             (issue_b),
    .issue_tag           (issue_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs settle here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [1:0] op, input logic [3:0] a, input logic av,
                          input logic [3:0] b, input logic bv);
    dispatch_valid      = 1'b1;
    dispatch_op         = op;
    dispatch_a          = a;
    dispatch_a_is_valid = av;
    dispatch_b          = b;
    dispatch_b_is_valid = bv;
  endtask

  task automatic cdb(input logic v, input logic [3:0] t, input logic [3:0] d);
    cdb_in_valid = v;
    cdb_in_tag   = t;
    cdb_in_data  = d;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; issue_ready = 1'b0;
    dispatch_valid = 1'b0; dispatch_op = '0; dispatch_a = '0; dispatch_b = '0;
    dispatch_a_is_valid = 1'b0; dispatch_b_is_valid = 1'b0;
    cdb(1'b0, 4'h0, 4'h0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset_dispatch_ready", 32'(dispatch_ready), 32'd1);
    chk("reset_issue_valid", 32'(issue_valid), 32'd0);

    // Both operands valid at dispatch: issue one cycle later
    dispatch(2'd2, 4'd5, 1'b1, 4'd3, 1'b1);
    tick();
    dispatch_valid = 1'b0;
    #1;
    chk("t1_issue_valid", 32'(issue_valid), 32'd1);
    chk("t1_issue_a", 32'(issue_a), 32'h5);
    chk("t1_issue_b", 32'(issue_b), 32'h3);
    chk("t1_issue_op", 32'(issue_op), 32'd2);
    chk("t1_issue_tag", 32'(issue_tag), 32'd1);
    chk("t1_waiting_not_ready", 32'(dispatch_ready), 32'd0);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    #1;
    chk("t1_issued_valid", 32'(issue_valid), 32'd0);
    chk("t1_issued_ready", 32'(dispatch_ready), 32'd0);
    cdb(1'b1, 4'd1, 4'hF);
    #1;
    chk("t1_release_same_cycle", 32'(dispatch_ready), 32'd0);
    tick();
    cdb(1'b0, 4'd0, 4'd0);
    #1;
    chk("t1_release_next_cycle", 32'(dispatch_ready), 32'd1);

    // Operand A waits for tag 3, delivered on the CDB two cycles later
    dispatch(2'd1, 4'd3, 1'b0, 4'd7, 1'b1);
    tick();
    dispatch_valid = 1'b0;
    #1;
    chk("t2_wait0", 32'(issue_valid), 32'd0);
    tick();
    #1;
    chk("t2_wait1", 32'(issue_valid), 32'd0);
    cdb(1'b1, 4'd3, 4'd9);
    #1;
    chk("t2_cdb_cycle", 32'(issue_valid), 32'd0);
    tick();
    cdb(1'b0, 4'd0, 4'd0);
    #1;
    chk("t2_issue_valid", 32'(issue_valid), 32'd1);
    chk("t2_issue_a", 32'(issue_a), 32'h9);
    chk("t2_issue_b", 32'(issue_b), 32'h7);
    chk("t2_issue_op", 32'(issue_op), 32'd1);
    // Backpressure: outputs hold for three stalled cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 32'(issue_valid), 32'd1);
      chk("stall_a", 32'(issue_a), 32'h9);
      chk("stall_b", 32'(issue_b), 32'h7);
      chk("stall_op", 32'(issue_op), 32'd1);
    end
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    #1;
    chk("t2_issued_valid", 32'(issue_valid), 32'd0);
    chk("t2_issued_ready", 32'(dispatch_ready), 32'd0);
    cdb(1'b1, 4'd2, 4'd4);
    tick();
    cdb(1'b0, 4'd0, 4'd0);
    #1;
    chk("t2_foreign_tag_holds", 32'(dispatch_ready), 32'd0);
    cdb(1'b1, 4'd1, 4'd4);
    tick();
    cdb(1'b0, 4'd0, 4'd0);
    #1;
    chk("t2_release", 32'(dispatch_ready), 32'd1);

    // Same-cycle forwarding of the dispatched tag
    dispatch(2'd3, 4'd4, 1'b0, 4'd6, 1'b1);
    cdb(1'b1, 4'd4, 4'hA);
    tick();
    dispatch_valid = 1'b0;
    cdb(1'b0, 4'd0, 4'd0);
    #1;
    chk("t3_fwd_valid", 32'(issue_valid), 32'd1);
    chk("t3_fwd_a", 32'(issue_a), 32'hA);
    chk("t3_fwd_b", 32'(issue_b), 32'h6);
    chk("t3_fwd_op", 32'(issue_op), 32'd3);
    // Own-tag broadcast while waiting must not release the entry
    cdb(1'b1, 4'd1, 4'h2);
    tick();
    cdb(1'b0, 4'd0, 4'd0);
    #1;
    chk("t3_owntag_waiting", 32'(issue_valid), 32'd1);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    #1;
    chk("t3_issued_ready", 32'(dispatch_ready), 32'd0);
    // Reset while issued
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t3_rst_ready", 32'(dispatch_ready), 32'd1);
    chk("t3_rst_valid", 32'(issue_valid), 32'd0);

    // Flush while waiting, with a matching CDB broadcast
    dispatch(2'd0, 4'd5, 1'b0, 4'd2, 1'b1);
    tick();
    dispatch_valid = 1'b0;
    #1;
    chk("t4_waiting", 32'(issue_valid), 32'd0);
    flush = 1'b1;
    cdb(1'b1, 4'd5, 4'd8);
    #1;
    chk("t4_flush_ready", 32'(dispatch_ready), 32'd0);
    tick();
    flush = 1'b0;
    cdb(1'b0, 4'd0, 4'd0);
    #1;
    chk("t4_flushed_ready", 32'(dispatch_ready), 32'd1);
    chk("t4_flushed_valid", 32'(issue_valid), 32'd0);

    // Flush overrides an accept in FREE
    dispatch(2'd1, 4'd1, 1'b1, 4'd1, 1'b1);
    flush = 1'b1;
    #1;
    chk("t5_flush_blocks_ready", 32'(dispatch_ready), 32'd0);
    tick();
    flush = 1'b0;
    dispatch_valid = 1'b0;
    #1;
    chk("t5_still_free", 32'(dispatch_ready), 32'd1);
    chk("t5_no_issue", 32'(issue_valid), 32'd0);

    // Flush retracts issue_valid and overrides an issue handshake
    dispatch(2'd2, 4'd6, 1'b1, 4'd7, 1'b1);
    tick();
    dispatch_valid = 1'b0;
    #1;
    chk("t6_valid", 32'(issue_valid), 32'd1);
    flush = 1'b1;
    issue_ready = 1'b1;
    #1;
    chk("t6_flush_retracts", 32'(issue_valid), 32'd0);
    tick();
    flush = 1'b0;
    issue_ready = 1'b0;
    #1;
    chk("t6_free_after_flush", 32'(dispatch_ready), 32'd1);
    chk("t6_no_issue", 32'(issue_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
